// File: rtl/mdu_pkg.sv
// Shared encodings and op-class helpers for the iterative multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic is_div(mdu_op_e op);
      return op inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
   endfunction

   function automatic logic is_rem(mdu_op_e op);
      return op inside {MDU_REM, MDU_REMU};
   endfunction

   function automatic logic is_signed_a(mdu_op_e op);
      return op inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic is_signed_b(mdu_op_e op);
      return op inside {MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Start/done handshake bundle between the execute-stage control and the multiply/divide unit.
interface mul_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             flush;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] y;
   logic             zero;

   modport master (output start, flush, op, a, b, input busy, done, y, zero);
   modport slave  (input start, flush, op, a, b, output busy, done, y, zero);
endinterface

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate: magnitude conversion on entry and sign restore on exit.
module mdu_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val,
   input  logic             neg,
   output logic [WIDTH-1:0] res
);

   assign res = neg ? (~val + {{(WIDTH-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit (RV32M semantics at WIDTH bits), start/done handshake.
//
// state   | meaning
// IDLE    | waiting for start; special cases resolve straight to DONE
// CALC    | one shift-add or restoring shift-subtract step per cycle, cnt counts down to 1
// FIX     | sign correction and half/quotient/remainder select, y and zero written
// DONE    | done pulse, back to IDLE
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   mul_div_unit_if.slave bus
);

   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   mdu_state_e         state;
   mdu_op_e            op_in;
   mdu_op_e            op_q;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_step;
   logic [2*WIDTH-1:0] fix_raw;
   logic [2*WIDTH-1:0] fix_res;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH-1:0]   y_special;
   logic [WIDTH-1:0]   y_fix;
   logic [WIDTH-1:0]   y_r;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_cand;
   logic [WIDTH:0]     rem_diff;
   logic               neg_a;
   logic               neg_b;
   logic               neg_in;
   logic               neg_q;
   logic               div_by_zero;
   logic               ovf;
   logic               special;
   logic               busy_r;
   logic               done_r;
   logic               zero_r;

   assign op_in = mdu_op_e'(bus.op);
   assign neg_a = is_signed_a(op_in) & bus.a[WIDTH-1];
   assign neg_b = is_signed_b(op_in) & bus.b[WIDTH-1];

   mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_a (.val(bus.a), .neg(neg_a), .res(mag_a));
   mdu_sign_fix #(.WIDTH(WIDTH)) u_mag_b (.val(bus.b), .neg(neg_b), .res(mag_b));

   always_comb begin
      div_by_zero = is_div(op_in) && (bus.b == '0);
      ovf         = ((op_in == MDU_DIV) || (op_in == MDU_REM)) && (bus.a == MIN_VAL) && (bus.b == '1);
      special     = div_by_zero || ovf;
      if (div_by_zero) begin
         y_special = is_rem(op_in) ? bus.a : '1;
      end else begin
         y_special = is_rem(op_in) ? '0 : bus.a;
      end
      // remainder follows the dividend; products and quotients follow the operand sign xor
      neg_in = is_rem(op_in) ? neg_a : (neg_a ^ neg_b);
   end

   // prod holds {partial product, multiplier} for MUL*, {remainder, quotient} for DIV*/REM*
   always_comb begin
      add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      rem_cand = prod[2*WIDTH-1:WIDTH-1];
      rem_diff = rem_cand - {1'b0, opnd};
      if (is_div(op_q)) begin
         if (!rem_diff[WIDTH]) begin
            prod_step = {rem_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
         end else begin
            prod_step = {rem_cand[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
         end
      end else if (prod[0]) begin
         prod_step = {add_sum, prod[WIDTH-1:1]};
      end else begin
         prod_step = {1'b0, prod[2*WIDTH-1:WIDTH], prod[WIDTH-1:1]};
      end
   end

   always_comb begin
      if (is_div(op_q)) begin
         fix_raw = {{WIDTH{1'b0}}, is_rem(op_q) ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0]};
      end else begin
         fix_raw = prod;
      end
      y_fix = ((op_q == MDU_MUL) || is_div(op_q)) ? fix_res[WIDTH-1:0] : fix_res[2*WIDTH-1:WIDTH];
   end

   // negating the zero-extended quotient/remainder at 2*WIDTH leaves the correct low half
   mdu_sign_fix #(.WIDTH(2*WIDTH)) u_res_fix (.val(fix_raw), .neg(neg_q), .res(fix_res));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         op_q   <= MDU_MUL;
         cnt    <= '0;
         prod   <= '0;
         opnd   <= '0;
         neg_q  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         y_r    <= '0;
         zero_r <= 1'b1;
      end else if (bus.flush) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  op_q   <= op_in;
                  busy_r <= 1'b1;
                  if (special) begin
                     y_r    <= y_special;
                     zero_r <= (y_special == '0);
                     done_r <= 1'b1;
                     state  <= ST_DONE;
                  end else begin
                     neg_q <= neg_in;
                     opnd  <= is_div(op_in) ? mag_b : mag_a;
                     prod  <= {{WIDTH{1'b0}}, is_div(op_in) ? mag_a : mag_b};
                     cnt   <= CNT_W'(WIDTH);
                     state <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               prod <= prod_step;
               cnt  <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               y_r    <= y_fix;
               zero_r <= (y_fix == '0);
               done_r <= 1'b1;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
               state  <= ST_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_r;
   assign bus.done = done_r;
   assign bus.y    = y_r;
   assign bus.zero = zero_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit at WIDTH=32 and WIDTH=8 against an arithmetic reference model.
module tb_mul_div_unit;
   import mdu_pkg::*;

   localparam time PERIOD = 10;

   typedef struct {
      logic [31:0] y;
      logic        zero;
      int          lat;
      time         t0;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_div_unit_if #(.WIDTH(32)) bus32 ();
   mul_div_unit_if #(.WIDTH(8))  bus8 ();

   mul_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   mul_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

   exp_t        q32[$];
   exp_t        q8[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] last_y32 = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] wmask(int w);
      return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic longint sx(logic [31:0] x, int w);
      longint v;
      v = longint'({32'd0, x});
      if (x[w-1]) v = v - (longint'(1) << w);
      return v;
   endfunction

   function automatic logic ref_special(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w);
      logic [31:0] m;
      m = wmask(w);
      if (op[2] && ((b & m) == 0)) return 1'b1;
      return ((op == 3'd4) || (op == 3'd6)) && (sx(a & m, w) == -(longint'(1) << (w - 1))) && (sx(b & m, w) == -1);
   endfunction

   // plain integer arithmetic: SV / and % truncate toward zero, matching RV32M
   function automatic logic [31:0] ref_y(logic [2:0] op, logic [31:0] a, logic [31:0] b, int w);
      longint unsigned m, ua, ub, r;
      longint          sa, sb;
      logic            ovf;
      m   = (longint'(1) << w) - 1;
      ua  = {32'd0, a} & m;
      ub  = {32'd0, b} & m;
      sa  = sx(ua[31:0], w);
      sb  = sx(ub[31:0], w);
      ovf = (sa == -(longint'(1) << (w - 1))) && (sb == -1);
      case (op)
         3'd0: r = ua * ub;
         3'd1: r = (sa * sb) >>> w;
         3'd2: r = (sa * longint'(ub)) >>> w;
         3'd3: r = (ua * ub) >> w;
         3'd4: r = (ub == 0) ? m : (ovf ? ua : longint'(sa / sb));
         3'd5: r = (ub == 0) ? m : ua / ub;
         3'd6: r = (ub == 0) ? ua : (ovf ? 0 : longint'(sa % sb));
         default: r = (ub == 0) ? ua : ua % ub;
      endcase
      return 32'(r & m);
   endfunction

   function automatic logic busy_of(int w);
      return (w == 32) ? bus32.busy : bus8.busy;
   endfunction

   task automatic drive(input int w, input logic st, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (w == 32) begin
         bus32.start = st; bus32.op = op; bus32.a = a; bus32.b = b;
      end else begin
         bus8.start = st; bus8.op = op; bus8.a = a[7:0]; bus8.b = b[7:0];
      end
   endtask

   task automatic wait_idle(input int w);
      int n = 0;
      while (busy_of(w) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy_of(w)) check($sformatf("idle_timeout_w%0d", w), 64'(busy_of(w)), 64'd0);
   endtask

   task automatic issue(input int w, input logic [2:0] op, input logic [31:0] a_in, input logic [31:0] b_in);
      exp_t        e;
      logic [31:0] a, b;
      a = a_in & wmask(w);
      b = b_in & wmask(w);
      wait_idle(w);
      drive(w, 1'b1, op, a, b);
      @(posedge clk);
      e.t0   = $time;
      e.y    = ref_y(op, a, b, w);
      e.zero = (e.y == 32'd0);
      e.lat  = ref_special(op, a, b, w) ? 1 : w + 2;
      if (w == 32) q32.push_back(e); else q8.push_back(e);
      @(negedge clk);
      check($sformatf("busy_after_start_w%0d", w), 64'(busy_of(w)), 64'd1);
      drive(w, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus32.done) begin
         if (q32.size() == 0) begin
            check("spurious_done_w32", 64'(bus32.done), 64'd0);
         end else begin
            e = q32.pop_front();
            check("y_w32", 64'(bus32.y), 64'(e.y));
            check("zero_w32", 64'(bus32.zero), 64'(e.zero));
            check("latency_w32", 64'(($time - e.t0) / PERIOD + 1), 64'(e.lat));
            last_y32 = e.y;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus8.done) begin
         if (q8.size() == 0) begin
            check("spurious_done_w8", 64'(bus8.done), 64'd0);
         end else begin
            e = q8.pop_front();
            check("y_w8", 64'(bus8.y), 64'(e.y));
            check("zero_w8", 64'(bus8.zero), 64'(e.zero));
            check("latency_w8", 64'(($time - e.t0) / PERIOD + 1), 64'(e.lat));
         end
      end
   end

   initial begin
      logic [31:0] a, b;
      logic [2:0]  op;
      int          n;
      drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
      drive(8, 1'b0, 3'd0, 32'd0, 32'd0);
      bus32.flush = 1'b0;
      bus8.flush  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(bus32.busy), 64'd0);
      check("rst_done", 64'(bus32.done), 64'd0);
      check("rst_y", 64'(bus32.y), 64'd0);
      check("rst_zero", 64'(bus32.zero), 64'd1);
      check("rst_zero_w8", 64'(bus8.zero), 64'd1);
      rst_n = 1'b1;
      @(negedge clk);

      issue(32, MDU_MUL,    32'd3,        32'd4);
      issue(32, MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(32, MDU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF);
      issue(32, MDU_MULHSU, 32'hFFFFFFFF, 32'd2);
      issue(32, MDU_DIV,    32'hFFFFFFF9, 32'd2);
      issue(32, MDU_REM,    32'hFFFFFFF9, 32'd2);
      issue(32, MDU_DIVU,   32'd9,        32'd4);
      issue(32, MDU_REMU,   32'd9,        32'd4);
      issue(32, MDU_DIV,    32'd7,        32'd0);
      issue(32, MDU_REMU,   32'd7,        32'd0);
      issue(32, MDU_DIV,    32'h80000000, 32'hFFFFFFFF);
      issue(32, MDU_REM,    32'h80000000, 32'hFFFFFFFF);

      // start pulses while busy must be ignored; the IDLE cycle after DONE accepts
      issue(32, MDU_MUL, 32'd3, 32'd4);
      n = 0;
      while (bus32.busy && n < 100) begin
         drive(32, 1'b1, MDU_MUL, 32'd5, 32'd6);
         @(negedge clk);
         n++;
      end
      issue(32, MDU_MUL, 32'd5, 32'd6);
      wait_idle(32);

      drive(32, 1'b1, MDU_DIV, 32'd100, 32'd7);
      @(posedge clk);
      @(negedge clk);
      drive(32, 1'b0, MDU_DIV, 32'd0, 32'd0);
      repeat (9) @(negedge clk);
      check("busy_before_flush", 64'(bus32.busy), 64'd1);
      bus32.flush = 1'b1;
      @(negedge clk);
      bus32.flush = 1'b0;
      check("busy_after_flush", 64'(bus32.busy), 64'd0);
      check("y_kept_after_flush", 64'(bus32.y), 64'(last_y32));
      repeat (40) @(negedge clk);
      check("idle_after_flush", 64'(bus32.busy), 64'd0);

      bus32.flush = 1'b1;
      drive(32, 1'b1, MDU_MUL, 32'd3, 32'd4);
      @(negedge clk);
      bus32.flush = 1'b0;
      drive(32, 1'b0, MDU_MUL, 32'd0, 32'd0);
      check("flush_beats_start", 64'(bus32.busy), 64'd0);
      repeat (40) @(negedge clk);

      drive(32, 1'b1, MDU_MUL, 32'd9, 32'd9);
      @(posedge clk);
      @(negedge clk);
      drive(32, 1'b0, MDU_MUL, 32'd0, 32'd0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midop_rst_busy", 64'(bus32.busy), 64'd0);
      check("midop_rst_y", 64'(bus32.y), 64'd0);
      check("midop_rst_zero", 64'(bus32.zero), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(8, MDU_MUL,   32'h0F, 32'h11);
      issue(8, MDU_MULHU, 32'hFF, 32'hFF);
      issue(8, MDU_MULH,  32'hFF, 32'hFF);
      issue(8, MDU_DIV,   32'hF9, 32'h02);
      issue(8, MDU_REM,   32'hF9, 32'h02);
      issue(8, MDU_DIV,   32'h07, 32'h00);
      issue(8, MDU_REMU,  32'h07, 32'h00);
      issue(8, MDU_DIV,   32'h80, 32'hFF);
      issue(8, MDU_REM,   32'h80, 32'hFF);

      for (int i = 0; i < 1000; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 15))
            0: b = 32'd0;
            1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            2: b = 32'd1;
            3: a = 32'($urandom_range(0, 15));
            default: ;
         endcase
         issue(32, op, a, b);
      end

      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: begin a = 32'h80; b = 32'hFF; end
            default: ;
         endcase
         issue(8, op, a, b);
      end

      wait_idle(32);
      wait_idle(8);
      repeat (3) @(negedge clk);
      check("drain_w32", 64'(q32.size()), 64'd0);
      check("drain_w8", 64'(q8.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
